// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters with registered,
// zero-latency sync, blanking, data-enable and frame-start decode.
module video_timing_gen #(
    parameter int unsigned HW       = 10,
    parameter int unsigned VW       = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          run,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_HB,
    output logic          VGA_VB,
    output logic          VGA_DE,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Reject geometries the counters cannot represent.
    if (H_BP == 0) begin : g_bad_hbp
        $error("video_timing_gen: H_BP must be at least 1");
    end
    if (V_BP == 0) begin : g_bad_vbp
        $error("video_timing_gen: V_BP must be at least 1");
    end
    if (longint'(H_TOTAL) > (longint'(1) << HW)) begin : g_bad_hw
        $error("video_timing_gen: HW too small for H_TOTAL-1");
    end
    if (longint'(V_TOTAL) > (longint'(1) << VW)) begin : g_bad_vw
        $error("video_timing_gen: VW too small for V_TOTAL-1");
    end

    // A nonzero back porch keeps every sync end value inside the counter range.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_BLANK    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_BLANK    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          hb_q, hb_d;
    logic          vb_q, vb_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic          advance;
    logic          h_wrap;
    logic          v_wrap;

    // Next counter values, then decode of those values so outputs align with counters.
    always_comb begin
        advance  = ce_pix & run;
        h_wrap   = (hcount_q == H_LAST);
        v_wrap   = (vcount_q == V_LAST);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (advance) begin
            if (h_wrap) begin
                hcount_d = '0;
                vcount_d = v_wrap ? '0 : vcount_q + VW'(1);
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end
        hb_d = (hcount_d >= H_BLANK);
        vb_d = (vcount_d >= V_BLANK);
        de_d = ~hb_d & ~vb_d & run;
        hs_d = ((hcount_d >= H_HS_START) && (hcount_d < H_HS_END)) ? HS_POL : ~HS_POL;
        vs_d = ((vcount_d >= V_VS_START) && (vcount_d < V_VS_END)) ? VS_POL : ~VS_POL;
        fs_d = advance && (hcount_d == '0) && (vcount_d == '0);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            hb_q     <= 1'b1;
            vb_q     <= 1'b1;
            de_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hb_q     <= hb_d;
            vb_q     <= vb_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_HB      = hb_q;
    assign VGA_VB      = vb_q;
    assign VGA_DE      = de_q;
    assign frame_start = fs_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed-mode timing logic inside the soc video path.
- Produces pixel counters, sync, blanking and data-enable for any mode chosen by parameters.
- Adds programmable sync polarity, a pixel clock-enable, a run/hold control and a frame-start strobe.
- Sits between the clock domain and the pixel/line fetch logic; drives VGA_* toward the top level.

Parameters:
- HW, 10, hcount width in bits; must hold H_TOTAL-1.
- VW, 10, vcount width in bits; must hold V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels; must be >=1.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines; must be >=1.
- HS_POL, 0, HS asserted level (0 = active-low).
- VS_POL, 0, VS asserted level (0 = active-low).

Ports:
- clk_sys, input, 1, sole clock.
- reset, input, 1, asynchronous, active-high.
- ce_pix, input, 1, pixel clock enable; counters advance only on clk_sys edges where ce_pix=1.
- run, input, 1, 1 = advance; 0 = hold counters and force VGA_DE=0.
- hcount, output, HW, current pixel column.
- vcount, output, VW, current line.
- VGA_HS, output, 1, horizontal sync at HS_POL.
- VGA_VS, output, 1, vertical sync at VS_POL.
- VGA_HB, output, 1, horizontal blank.
- VGA_VB, output, 1, vertical blank.
- VGA_DE, output, 1, data enable.
- frame_start, output, 1, one-clk_sys pulse on entry to (0,0).

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration fails if a width is too small or a BP is 0.
- Reset (async): hcount=H_TOTAL-1, vcount=V_TOTAL-1, VGA_HB=1, VGA_VB=1, VGA_DE=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, frame_start=0.
- Advance occurs on an edge with ce_pix=1 and run=1:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 only when hcount also wraps.
- All outputs are registered and aligned with the counters (zero latency): each output equals the decode of the hcount/vcount value it is presented with.
- Decode:
  - HB = hcount >= H_ACTIVE.
  - VB = vcount >= V_ACTIVE.
  - DE = ~HB & ~VB & run.
  - HS asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - VS asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. VS changes only at the hcount wrap.
- frame_start is 1 for exactly one clk_sys cycle, in the cycle where the counters first show (0,0) after an advance. It is 0 on all other cycles, including cycles with ce_pix=0.
- ce_pix=0: all outputs hold; frame_start=0.
- run=0: counters, HS, VS, HB and VB hold. DE drops to 0 on the next clk_sys edge regardless of ce_pix. When run returns to 1, DE recovers on the next edge and advancing resumes on the next ce_pix.
- First advance after reset lands on (0,0): DE=1 and frame_start pulses.
- Reset asserted mid-frame: outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Default parameters, ce_pix=1, run=1 after reset:
  - First edge gives hcount=0, vcount=0, DE=1, frame_start=1.
  - DE high for exactly 640 consecutive cycles per line.
  - 800 cycles per line; frame_start period = 420000 cycles.
- Small mode H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1:
  - HS low exactly at hcount 5,6.
  - HB high at hcount 4..7.
  - VS low for all 8 cycles of vcount=3.
  - frame_start every 40 cycles.
- HS_POL=1, VS_POL=1: sync pulses become high-true with identical positions; idle level 0 after reset.
- ce_pix alternating 1/0:
  - Line length = 1600 clk_sys cycles.
  - frame_start width = 1 cycle.
  - Outputs stable across ce_pix=0 cycles.
- run dropped at hcount=100, vcount=10 for 5 cycles:
  - DE=0 during the hold; counters frozen at (100,10).
  - Advancing resumes to hcount=101.
- Reset asserted at hcount=300, vcount=200:
  - Outputs return immediately to reset values (hcount=799, vcount=524, HB=VB=1, DE=0).
  - After release, the first advance gives (0,0) with frame_start=1.
